// File: rtl/buzzer_sequencer.sv
// Note-queue buzzer driver: register-mapped FIFO of {half-period, duration} words
// played back as a square wave with a one-tick silent gap after each note.
module buzzer_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int PRESCALE   = 256,
  parameter int TICK_DIV   = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        write_enable,
  input  logic        read_enable,
  input  logic [15:0] write_data_in,
  output logic [15:0] read_data_out,
  output logic        buzzer_output,
  output logic        irq
);

  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TONE_W = $clog2(255 * PRESCALE + 1);
  localparam int TICK_W = $clog2(TICK_DIV + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_t;

  state_t             state_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [3:0]         count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               enable_q, irq_en_q, irq_q;
  logic               buz_q;
  logic [15:0]        mem_q [FIFO_DEPTH];
  logic [15:0]        head_q;
  logic [TONE_W-1:0]  tone_lim_q, tone_cnt_q;
  logic [TICK_W-1:0]  tick_cnt_q;
  logic [7:0]         dur_q, ticks_q;

  logic note_wr, ctrl_wr, flush, stat_rd;
  logic full, empty, busy, push_ok, push_rej, pop;

  assign note_wr  = write_enable && (address == 2'd0);
  assign ctrl_wr  = write_enable && (address == 2'd1);
  assign flush    = ctrl_wr && write_data_in[1];
  assign stat_rd  = read_enable && (address == 2'd2);
  assign full     = (count_q == 4'(FIFO_DEPTH));
  assign empty    = (count_q == 4'd0);
  assign busy     = (state_q != S_IDLE);
  // Fullness is taken from the registered count, so a same-cycle pop never frees room.
  assign push_ok  = note_wr && !full;
  assign push_rej = note_wr && full;
  assign pop      = (state_q == S_IDLE) && enable_q && !empty && !flush;

  assign read_data_out = stat_rd ? {8'h00, count_q, ovf_q, empty, full, busy} : 16'h0000;
  assign buzzer_output = buz_q;
  assign irq           = irq_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = 4'd0;
    end else begin
      case ({push_ok, pop})
        2'b10:   count_d = count_q + 4'd1;
        2'b01:   count_d = count_q - 4'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (push_rej) begin
      ovf_d = 1'b1;
    end else if (stat_rd) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
      ovf_q    <= 1'b0;
      enable_q <= 1'b0;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      irq_q   <= irq_en_q && enable_q && empty && (state_q == S_IDLE);
      if (ctrl_wr) begin
        enable_q <= write_data_in[0];
        irq_en_q <= write_data_in[2];
      end
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (push_ok) wr_ptr_q <= ptr_inc(wr_ptr_q);
        if (pop)     rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
    end
  end

  // Queue storage and head register carry no reset so they map onto block RAM.
  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= write_data_in;
    if (pop)     head_q <= mem_q[rd_ptr_q];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      buz_q      <= 1'b0;
      tone_lim_q <= '0;
      tone_cnt_q <= '0;
      tick_cnt_q <= '0;
      dur_q      <= 8'd0;
      ticks_q    <= 8'd0;
    end else if (flush) begin
      state_q    <= S_IDLE;
      buz_q      <= 1'b0;
      tone_cnt_q <= '0;
      tick_cnt_q <= '0;
      ticks_q    <= 8'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          buz_q <= 1'b0;
          if (pop) state_q <= S_LOAD;
        end
        S_LOAD: begin
          buz_q <= 1'b0;
          if (!enable_q) begin
            state_q <= S_IDLE;
          end else begin
            tone_lim_q <= TONE_W'(head_q[15:8]) * TONE_W'(PRESCALE);
            dur_q      <= head_q[7:0];
            tone_cnt_q <= '0;
            tick_cnt_q <= '0;
            ticks_q    <= 8'd0;
            state_q    <= (head_q[7:0] == 8'd0) ? S_IDLE : S_PLAY;
          end
        end
        S_PLAY: begin
          if (!enable_q) begin
            state_q <= S_IDLE;
            buz_q   <= 1'b0;
          end else begin
            if (tone_lim_q != '0) begin
              if (tone_cnt_q == tone_lim_q - TONE_W'(1)) begin
                tone_cnt_q <= '0;
                buz_q      <= ~buz_q;
              end else begin
                tone_cnt_q <= tone_cnt_q + TONE_W'(1);
              end
            end
            // The final tick edge overrides any same-edge toggle and silences the output.
            if (tick_cnt_q == TICK_W'(TICK_DIV - 1)) begin
              tick_cnt_q <= '0;
              if (ticks_q == dur_q - 8'd1) begin
                state_q <= S_GAP;
                buz_q   <= 1'b0;
              end else begin
                ticks_q <= ticks_q + 8'd1;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + TICK_W'(1);
            end
          end
        end
        S_GAP: begin
          buz_q <= 1'b0;
          if (!enable_q) begin
            state_q <= S_IDLE;
          end else if (tick_cnt_q == TICK_W'(TICK_DIV - 1)) begin
            tick_cnt_q <= '0;
            state_q    <= S_IDLE;
          end else begin
            tick_cnt_q <= tick_cnt_q + TICK_W'(1);
          end
        end
        default: begin
          state_q <= S_IDLE;
          buz_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Scoreboard bench for buzzer_sequencer: queued STATUS values and queued note
// timings are checked as the DUT produces them.
module tb_buzzer_sequencer;

  localparam int PS = 2;
  localparam int TD = 20;
  localparam int FD = 8;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  address = 2'd0;
  logic        write_enable = 1'b0;
  logic        read_enable = 1'b0;
  logic [15:0] write_data_in = 16'h0000;
  logic [15:0] read_data_out;
  logic        buzzer_output;
  logic        irq;

  always #5 clock = ~clock;

  buzzer_sequencer #(
    .FIFO_DEPTH(FD),
    .PRESCALE  (PS),
    .TICK_DIV  (TD)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .write_enable (write_enable),
    .read_enable  (read_enable),
    .write_data_in(write_data_in),
    .read_data_out(read_data_out),
    .buzzer_output(buzzer_output),
    .irq          (irq)
  );

  typedef struct {
    logic [7:0] half;
    logic [7:0] dur;
  } note_t;

  logic [15:0] exp_rd_q[$];
  note_t       note_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  function automatic logic [15:0] status_word(input int cnt, input bit ovf, input bit bsy);
    logic [3:0] c;
    c = 4'(cnt);
    return {8'h00, c, ovf, (cnt == 0), (cnt == FD), bsy};
  endfunction

  task automatic reg_write(input logic [1:0] addr, input logic [15:0] data);
    address       = addr;
    write_data_in = data;
    write_enable  = 1'b1;
    @(negedge clock);
    write_enable  = 1'b0;
    address       = 2'd0;
  endtask

  task automatic note_write(input logic [15:0] data, input bit accepted);
    note_t n;
    n.half = data[15:8];
    n.dur  = data[7:0];
    if (accepted) note_q.push_back(n);
    reg_write(2'd0, data);
  endtask

  task automatic status_read(input string tag, input logic [15:0] exp);
    exp_rd_q.push_back(exp);
    address     = 2'd2;
    read_enable = 1'b1;
    #1;
    check_eq(tag, {16'h0, read_data_out}, {16'h0, exp_rd_q.pop_front()});
    @(negedge clock);
    read_enable = 1'b0;
    address     = 2'd0;
  endtask

  task automatic wait_high(input string tag);
    bit seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      #1;
      if (buzzer_output === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check_eq(tag, {31'h0, seen}, 32'd1);
  endtask

  // Watches one note from busy rise to busy fall, polling STATUS every cycle.
  task automatic play_note(input string tag);
    note_t n;
    int    hp, n_tog, exp_tog, exp_busy;
    int    busy_n = 0, tog = 0, last_idx = -1, min_int = 99999, max_int = 0, tail = 0;
    bit    started = 1'b0, done = 1'b0;
    logic  prev = 1'b0, b, z;
    n        = note_q.pop_front();
    hp       = int'(n.half) * PS;
    n_tog    = (n.half == 0) ? 0 : (int'(n.dur) * TD - 1) / hp;
    exp_tog  = n_tog + (n_tog % 2);
    exp_busy = (n.dur == 0) ? 1 : 1 + int'(n.dur) * TD + TD;
    address     = 2'd2;
    read_enable = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      #1;
      b = read_data_out[0];
      z = buzzer_output;
      if (!started && b) started = 1'b1;
      if (started && !b) begin
        done = 1'b1;
        break;
      end
      if (started) begin
        busy_n++;
        if (z !== prev) begin
          tog++;
          if (last_idx >= 0) begin
            if (busy_n - last_idx < min_int) min_int = busy_n - last_idx;
            if (busy_n - last_idx > max_int) max_int = busy_n - last_idx;
          end
          last_idx = busy_n;
        end
        prev = z;
        tail = (z === 1'b0) ? tail + 1 : 0;
      end
      @(negedge clock);
    end
    read_enable = 1'b0;
    address     = 2'd0;
    check_eq({tag, " done"}, {31'h0, done}, 32'd1);
    check_eq({tag, " busy_cycles"}, busy_n, exp_busy);
    check_eq({tag, " toggles"}, tog, exp_tog);
    if (exp_tog >= 2) begin
      check_eq({tag, " min_half_period"}, min_int, hp);
      check_eq({tag, " max_half_period"}, max_int, hp);
    end
    if (n.dur != 0) check_eq({tag, " gap_silent"}, {31'h0, (tail >= TD)}, 32'd1);
    check_eq({tag, " buzzer_idle"}, {31'h0, buzzer_output}, 32'd0);
    check_eq({tag, " irq_at_idle"}, {31'h0, irq}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clock);
    check_eq("reset_buzzer", {31'h0, buzzer_output}, 32'd0);
    check_eq("reset_irq", {31'h0, irq}, 32'd0);
    reset = 1'b1;
    @(negedge clock);
    status_read("reset_status", status_word(0, 1'b0, 1'b0));

    // Single tone note.
    reg_write(2'd1, 16'h0001);
    note_write(16'h0302, 1'b1);
    play_note("tone_0302");

    // Rest note: busy but silent.
    note_write(16'h0001, 1'b1);
    play_note("rest_0001");

    // Overflow with playback disabled.
    reg_write(2'd1, 16'h0000);
    for (int i = 0; i < 9; i++) note_write(16'h0100 + 16'(i), (i < FD));
    status_read("overflow_status", status_word(FD, 1'b1, 1'b0));
    status_read("overflow_cleared", status_word(FD, 1'b0, 1'b0));
    reg_write(2'd1, 16'h0002);
    note_q.delete();
    status_read("flush_idle_status", status_word(0, 1'b0, 1'b0));

    // Flush during the first note's PLAY.
    note_write(16'h0302, 1'b1);
    note_write(16'h0201, 1'b1);
    note_write(16'h0101, 1'b1);
    reg_write(2'd1, 16'h0001);
    wait_high("flush_wait_play");
    reg_write(2'd1, 16'h0003);
    note_q.delete();
    check_eq("flush_buzzer", {31'h0, buzzer_output}, 32'd0);
    status_read("flush_status", status_word(0, 1'b0, 1'b0));

    // Enable cleared mid-note, then resumed with irq_en.
    reg_write(2'd1, 16'h0004);
    note_write(16'h0302, 1'b1);
    note_write(16'h0201, 1'b1);
    note_write(16'h0102, 1'b1);
    reg_write(2'd1, 16'h0005);
    wait_high("abort_wait_play");
    reg_write(2'd1, 16'h0004);
    @(negedge clock);
    void'(note_q.pop_front());
    check_eq("abort_buzzer", {31'h0, buzzer_output}, 32'd0);
    status_read("abort_status", status_word(2, 1'b0, 1'b0));
    check_eq("abort_irq", {31'h0, irq}, 32'd0);
    reg_write(2'd1, 16'h0005);
    play_note("resume_0201");
    play_note("resume_0102");
    @(negedge clock);
    #1;
    check_eq("irq_after_drain", {31'h0, irq}, 32'd1);

    // Asynchronous reset in the middle of a note.
    note_write(16'h0302, 1'b1);
    wait_high("reset_wait_play");
    #2;
    reset = 1'b0;
    #1;
    check_eq("async_reset_buzzer", {31'h0, buzzer_output}, 32'd0);
    note_q.delete();
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    status_read("post_reset_status", status_word(0, 1'b0, 1'b0));
    check_eq("post_reset_irq", {31'h0, irq}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
